arcade_input_cond: RTL
======================

Name: arcade_input_cond

Overview:
- Parametrised player-input conditioner between arcade_inputs and the game core. Generalises the fixed two-player, active-low p1/p2/sys packing of the MiST tops to N players and M buttons.
- Adds:
  - two-flop input synchronisation
  - frame-counted coin pulse stretching
  - per-button autofire
  - SOCD cleaning
- All timing is counted in video frames, taken from the core's vblank.

Parameters:
NUM_PLAYERS, 2, player count (1..4)
NUM_BUTTONS, 4, fire buttons per player (1..8)
COIN_FRAMES, 3, coin output high-time in frames (1..255)
AF_FRAMES, 2, autofire half-period base in frames (1..15)
ACTIVE_LOW, 1, 1 = outputs inverted (hardware convention), 0 = active-high

Ports:
clk_sys  in  1  system clock
reset  in  1  asynchronous, active-high reset
vbl  in  1  core vertical blank, level; its rising edge defines a frame
joy_in  in  NUM_PLAYERS*(4+NUM_BUTTONS)  per player {buttons[NUM_BUTTONS-1:0], right, left, down, up}, player 0 in LSBs, active-high
coin_in  in  NUM_PLAYERS  coin switches, active-high
start_in  in  NUM_PLAYERS  start buttons, active-high
service_in  in  1  service switch
af_mask  in  NUM_BUTTONS  autofire enable per button index, common to all players
af_rate  in  2  autofire half-period = (af_rate+1)*AF_FRAMES frames
pause  in  1  freezes the frame counters
joy_out  out  NUM_PLAYERS*(4+NUM_BUTTONS)  conditioned controls, same packing as joy_in
coin_out  out  NUM_PLAYERS  stretched coin pulses
start_out  out  NUM_PLAYERS  synchronised starts
service_out  out  1  synchronised service
frame_tick  out  1  one-cycle pulse on a vbl rising edge

Behaviour:
- Reset values:
  - all internal state and counters are 0
  - joy_out, coin_out, start_out and service_out equal the inactive level: all-ones if ACTIVE_LOW, else zero
  - frame_tick = 0
- Synchronisation:
  - every input, vbl included, passes through 2 flops
  - latency from input to output is 3 clk_sys cycles (2 sync + 1 output register)
  - af_mask and af_rate are sampled without synchronisation
- frame_tick:
  - registered, asserted for the cycle after synchronised vbl goes 0->1
  - suppressed while pause = 1
- Coin FSM, one per player: IDLE -> PULSE -> HOLD -> IDLE
  - IDLE: coin_out inactive. A synchronised coin rising edge -> PULSE, counter = COIN_FRAMES.
  - PULSE: coin_out active. Counter decrements on frame_tick; at 0 -> HOLD.
  - HOLD: coin_out inactive. Waits for coin_in low, then -> IDLE. A switch held for longer than the pulse yields exactly one pulse.
  - A new rising edge during PULSE is ignored.
  - A coin edge on the same cycle as frame_tick enters PULSE with the full count; no decrement that cycle.
- Autofire:
  - one shared phase flop and a 6-bit frame counter
  - on frame_tick, counter increments; when it reaches (af_rate+1)*AF_FRAMES-1 it clears and phase toggles
  - a change of af_rate clears the counter on the next frame_tick
  - for button b with af_mask[b] = 1: out = in & ~phase
  - phase restarts at 0 whenever no autofire button is held by any player, so the first shot is immediate
  - unmasked buttons pass through unchanged
- SOCD cleaning, always on:
  - left & right both high -> both low
  - up & down both high -> both low
- Polarity: applied last, after all conditioning, when ACTIVE_LOW = 1.
- Pause: freezes coin and autofire counters. Synchronisation and output registers keep running.
- Reset asserted mid-pulse drives coin_out inactive immediately (asynchronous), and the FSM returns to IDLE.

Optional Feature:
- Macro: ARCADE_INPUT_4WAY_EN.
- Defined:
  - a per-player 4-way restrictor sits after SOCD cleaning
  - state: a last-axis flop, 0 = vertical, 1 = horizontal
  - when exactly one axis is active, it is recorded
  - when a diagonal is held, only the most recently newly pressed axis passes; if both became active on the same cycle, vertical wins
  - the restrictor resets to vertical
- Undefined: 8-way directions pass through after SOCD cleaning. The restrictor logic is absent.

Test Plan:
- Reset: assert reset with all inputs high, ACTIVE_LOW=1 -> all outputs all-ones during reset; 3 cycles after release joy_out reflects inputs (SOCD applied), coin_out stays inactive.
- Coin stretch: COIN_FRAMES=3; coin_in[1] high for 1 cycle -> coin_out[1] active from cycle 3 after the edge until the 3rd following frame_tick, then inactive; coin_out[0] unchanged.
- Coin hold: coin_in[0] held high for 10 frames -> exactly one 3-frame pulse. Release and press again -> second pulse.
- Autofire: AF_FRAMES=2, af_rate=1, af_mask=4'b0001, P0 button0 held -> active on first cycle, toggles every 4 frame_ticks; button1 held -> steady.
- SOCD and pause:
  - left+right+up held -> only up active
  - pause=1 for 5 frames mid-coin-pulse -> pulse extended by 5 frames, frame_tick absent
- 4-way (macro defined): press up, then add right 2 frames later -> only right active; release right -> up active again.

Source files
------------

// File: rtl/arcade_input_cond.sv
// arcade_input_cond
//   Player-input conditioner between the raw arcade inputs and the game core.
//   It handles N players with M fire buttons each and provides:
//     - two-flop synchronisation of every input, vbl included
//     - a frame-counted coin pulse stretcher (one FSM per player)
//     - per-button autofire driven by a shared phase
//     - SOCD cleaning (opposing directions cancel)
//     - optional output inversion for active-low hardware
//   Time is counted in video frames. A frame is one rising edge of the
//   synchronised vbl.
//
//   Optional feature: define ARCADE_INPUT_4WAY_EN to add a per-player 4-way
//   restrictor after SOCD cleaning. Without it, directions stay 8-way.
//
// Ports
//   clk_sys     system clock
//   reset       asynchronous, active-high reset
//   vbl         core vertical blank (level)
//   joy_in      per player {buttons, right, left, down, up}, player 0 in LSBs
//   coin_in     coin switches, active-high
//   start_in    start buttons, active-high
//   service_in  service switch
//   af_mask     autofire enable per button index, shared by all players (not synchronised)
//   af_rate     autofire half-period = (af_rate+1)*AF_FRAMES frames (not synchronised)
//   pause       freezes the coin and autofire frame counters
//   joy_out     conditioned controls, same packing as joy_in
//   coin_out    stretched coin pulses
//   start_out   synchronised starts
//   service_out synchronised service
//   frame_tick  one-cycle pulse per frame; suppressed while paused
//
//   joy_out, coin_out, start_out and service_out are inverted when ACTIVE_LOW = 1.
//   The coin FSM state of each player can be read from coin_state[p].
module arcade_input_cond #(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_BUTTONS = 4,
    parameter int COIN_FRAMES = 3,
    parameter int AF_FRAMES   = 2,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                                   clk_sys,
    input  logic                                   reset,
    input  logic                                   vbl,
    input  logic [NUM_PLAYERS*(4+NUM_BUTTONS)-1:0] joy_in,
    input  logic [NUM_PLAYERS-1:0]                 coin_in,
    input  logic [NUM_PLAYERS-1:0]                 start_in,
    input  logic                                   service_in,
    input  logic [NUM_BUTTONS-1:0]                 af_mask,
    input  logic [1:0]                             af_rate,
    input  logic                                   pause,
    output logic [NUM_PLAYERS*(4+NUM_BUTTONS)-1:0] joy_out,
    output logic [NUM_PLAYERS-1:0]                 coin_out,
    output logic [NUM_PLAYERS-1:0]                 start_out,
    output logic                                   service_out,
    output logic                                   frame_tick
);
    localparam int PW = 4 + NUM_BUTTONS;
    localparam int JW = NUM_PLAYERS * PW;
    localparam int SW = JW + 2 * NUM_PLAYERS + 3;
    localparam logic [7:0] COIN_LOAD = 8'(COIN_FRAMES);
    localparam logic [5:0] AF_BASE   = 6'(AF_FRAMES);

    typedef enum logic [1:0] {
        COIN_IDLE  = 2'd0,
        COIN_PULSE = 2'd1,
        COIN_HOLD  = 2'd2
    } coin_state_t;

    // ---------------- input synchronisation ----------------
    logic [SW-1:0]          sync1, sync2;
    logic [1:0]             sync_fill;
    logic                   sync_ok;
    logic                   vbl_s, pause_s, service_s;
    logic [NUM_PLAYERS-1:0] coin_s, start_s;
    logic [JW-1:0]          joy_s;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sync1     <= '0;
            sync2     <= '0;
            sync_fill <= '0;
        end else begin
            sync1     <= {pause, service_in, start_in, coin_in, joy_in, vbl};
            sync2     <= sync1;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    assign {pause_s, service_s, start_s, coin_s, joy_s, vbl_s} = sync2;
    // The synchroniser holds reset zeros for two cycles. Coin edges seen in
    // that window are not real, so a switch held through reset gives no credit.
    assign sync_ok = sync_fill[1];

    // ---------------- frame tick ----------------
    logic vbl_prev;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            vbl_prev   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            vbl_prev   <= vbl_s;
            frame_tick <= vbl_s & ~vbl_prev & ~pause_s;
        end
    end

    // ---------------- coin stretcher ----------------
    coin_state_t            coin_state     [NUM_PLAYERS];
    coin_state_t            coin_state_nxt [NUM_PLAYERS];
    logic [7:0]             coin_cnt       [NUM_PLAYERS];
    logic [7:0]             coin_cnt_nxt   [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] coin_armed;   // last valid sample was low
    logic [NUM_PLAYERS-1:0] coin_active;

    always_comb begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            coin_state_nxt[p] = coin_state[p];
            coin_cnt_nxt[p]   = coin_cnt[p];
            coin_active[p]    = 1'b0;
            case (coin_state[p])
                COIN_IDLE: begin
                    if (coin_s[p] && coin_armed[p]) begin
                        coin_state_nxt[p] = COIN_PULSE;
                        coin_cnt_nxt[p]   = COIN_LOAD;
                    end
                end
                COIN_PULSE: begin
                    coin_active[p] = 1'b1;
                    if (frame_tick) begin
                        if (coin_cnt[p] <= 8'd1) begin
                            coin_state_nxt[p] = COIN_HOLD;
                            coin_cnt_nxt[p]   = 8'd0;
                        end else begin
                            coin_cnt_nxt[p] = coin_cnt[p] - 8'd1;
                        end
                    end
                end
                COIN_HOLD: begin
                    if (!coin_s[p]) coin_state_nxt[p] = COIN_IDLE;
                end
                default: coin_state_nxt[p] = COIN_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                coin_state[p] <= COIN_IDLE;
                coin_cnt[p]   <= 8'd0;
            end
            coin_armed <= '0;
        end else begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                coin_state[p] <= coin_state_nxt[p];
                coin_cnt[p]   <= coin_cnt_nxt[p];
            end
            coin_armed <= {NUM_PLAYERS{sync_ok}} & ~coin_s;
        end
    end

    assign coin_out = coin_active ^ {NUM_PLAYERS{ACTIVE_LOW}};

    // ---------------- autofire ----------------
    logic [5:0] af_cnt, af_last;
    logic [1:0] af_rate_q;
    logic       af_phase, af_held;

    assign af_last = (6'(af_rate) + 6'd1) * AF_BASE - 6'd1;

    always_comb begin
        af_held = 1'b0;
        for (int p = 0; p < NUM_PLAYERS; p++)
            af_held = af_held | (|(joy_s[p*PW+4 +: NUM_BUTTONS] & af_mask));
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            af_cnt    <= 6'd0;
            af_phase  <= 1'b0;
            af_rate_q <= 2'd0;
        end else begin
            // Holding the phase at 0 while idle makes the first shot immediate.
            if (!af_held) begin
                af_cnt   <= 6'd0;
                af_phase <= 1'b0;
            end else if (frame_tick) begin
                if (af_rate != af_rate_q) begin
                    af_cnt <= 6'd0;
                end else if (af_cnt >= af_last) begin
                    af_cnt   <= 6'd0;
                    af_phase <= ~af_phase;
                end else begin
                    af_cnt <= af_cnt + 6'd1;
                end
            end
            if (frame_tick) af_rate_q <= af_rate;
        end
    end

    // ---------------- direction / button conditioning ----------------
    logic [JW-1:0]          joy_cond;
    logic [3:0]             dir_raw, dir_c;
    logic [NUM_BUTTONS-1:0] btn_c;
`ifdef ARCADE_INPUT_4WAY_EN
    logic [NUM_PLAYERS-1:0] last_axis, axis_nxt, h_now, v_now, h_prev, v_prev;
`endif

    always_comb begin
        joy_cond = '0;
        dir_raw  = '0;
        dir_c    = '0;
        btn_c    = '0;
`ifdef ARCADE_INPUT_4WAY_EN
        axis_nxt = '0;
        h_now    = '0;
        v_now    = '0;
`endif
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            dir_raw = joy_s[p*PW +: 4];
            // {right, left, down, up}: opposing pairs cancel
            dir_c = {dir_raw[3] & ~dir_raw[2], dir_raw[2] & ~dir_raw[3],
                     dir_raw[1] & ~dir_raw[0], dir_raw[0] & ~dir_raw[1]};
`ifdef ARCADE_INPUT_4WAY_EN
            h_now[p]    = dir_c[3] | dir_c[2];
            v_now[p]    = dir_c[1] | dir_c[0];
            axis_nxt[p] = last_axis[p];
            if (h_now[p] && !v_now[p]) begin
                axis_nxt[p] = 1'b1;
            end else if (v_now[p] && !h_now[p]) begin
                axis_nxt[p] = 1'b0;
            end else if (h_now[p] && v_now[p]) begin
                // the axis that just became active wins; vertical on a tie
                if (!v_prev[p])      axis_nxt[p] = 1'b0;
                else if (!h_prev[p]) axis_nxt[p] = 1'b1;
            end
            if (h_now[p] && v_now[p]) begin
                if (axis_nxt[p]) dir_c[1:0] = 2'b00;
                else             dir_c[3:2] = 2'b00;
            end
`endif
            btn_c = joy_s[p*PW+4 +: NUM_BUTTONS] & ~(af_mask & {NUM_BUTTONS{af_phase}});
            joy_cond[p*PW +: PW] = {btn_c, dir_c};
        end
    end

`ifdef ARCADE_INPUT_4WAY_EN
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            last_axis <= '0;
            h_prev    <= '0;
            v_prev    <= '0;
        end else begin
            last_axis <= axis_nxt;
            h_prev    <= h_now;
            v_prev    <= v_now;
        end
    end
`endif

    // ---------------- output registers ----------------
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            joy_out     <= {JW{ACTIVE_LOW}};
            start_out   <= {NUM_PLAYERS{ACTIVE_LOW}};
            service_out <= ACTIVE_LOW;
        end else begin
            joy_out     <= joy_cond ^ {JW{ACTIVE_LOW}};
            start_out   <= start_s ^ {NUM_PLAYERS{ACTIVE_LOW}};
            service_out <= service_s ^ ACTIVE_LOW;
        end
    end

endmodule
